// File: rtl/enc8_3_pend_pkg.sv
// Shared definitions for the 8-to-3 select path: widths plus the priority and
// lowest-set-bit helpers reused by the interrupt and select logic.
package enc8_3_pend_pkg;

    localparam int ENC_W = 3;
    localparam int REQ_N = 8;

    // Lowest index wins; returns 0 when nothing is set.
    function automatic logic [ENC_W-1:0] prienc8(input logic [REQ_N-1:0] v);
        logic [ENC_W-1:0] c;
        c = '0;
        for (int i = REQ_N - 1; i >= 0; i--) begin
            if (v[i]) c = ENC_W'(i);
        end
        return c;
    endfunction

    function automatic logic [REQ_N-1:0] lsb_onehot8(input logic [REQ_N-1:0] v);
        return v & (~v + REQ_N'(1));
    endfunction

endpackage

// File: rtl/enc8_3_pend_prienc8_3.sv
// Combinational lowest-index priority encoder: code of the first set bit and
// an any-set flag.
module prienc8_3
    import enc8_3_pend_pkg::*;
(
    input  logic [REQ_N-1:0] vec,
    output logic [ENC_W-1:0] code,
    output logic             any
);

    assign code = prienc8(vec);
    assign any  = |vec;

endmodule

// File: rtl/enc8_3_pend.sv
// Registered 8-to-3 priority encoder with sticky pending requests; each
// acknowledged code clears exactly its own pending bit.
module enc8_3_pend
    import enc8_3_pend_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [REQ_N-1:0] req,
    input  logic [REQ_N-1:0] mask,
    input  logic             ack,
    output logic [ENC_W-1:0] code,
    output logic             valid,
    output logic [REQ_N-1:0] pending,
    output logic [REQ_N-1:0] onehot
);

    logic [REQ_N-1:0] set;
    logic [REQ_N-1:0] clr;
    logic [REQ_N-1:0] pnext;
    logic [ENC_W-1:0] code_nxt;
    logic             any_nxt;

    assign set = req & mask & {REQ_N{en}};
    assign clr = onehot & {REQ_N{ack & valid}};
    // Set is OR-ed after the clear so a fresh request on the acked bit survives.
    assign pnext = (pending & ~clr) | set;

    prienc8_3 u_prienc (
        .vec  (pnext),
        .code (code_nxt),
        .any  (any_nxt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
            code    <= '0;
            valid   <= 1'b0;
            onehot  <= '0;
        end else begin
            pending <= pnext;
            code    <= code_nxt;
            valid   <= any_nxt;
            onehot  <= lsb_onehot8(pnext);
        end
    end

endmodule

// File: tb/tb_enc8_3_pend.sv
// Directed bench for enc8_3_pend with hand-computed expectations.
module tb_enc8_3_pend;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic [7:0] onehot;

    int checks   = 0;
    int failures = 0;

    enc8_3_pend dut (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .req     (req),
        .mask    (mask),
        .ack     (ack),
        .code    (code),
        .valid   (valid),
        .pending (pending),
        .onehot  (onehot)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample on the falling edge and check the
    // onehot/code/valid invariant.
    task automatic step();
        logic [7:0] oh_exp;
        @(posedge clock);
        @(negedge clock);
        oh_exp = valid ? (8'h01 << code) : 8'h00;
        chk("invariant_onehot", {24'd0, onehot}, {24'd0, oh_exp});
        if (valid) chk("invariant_code_pending", {31'd0, pending[code]}, 32'd1);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] p, input logic [2:0] c,
                           input logic v, input logic [7:0] oh);
        chk({tag, "_pending"}, {24'd0, pending}, {24'd0, p});
        chk({tag, "_code"},    {29'd0, code},    {29'd0, c});
        chk({tag, "_valid"},   {31'd0, valid},   {31'd0, v});
        chk({tag, "_onehot"},  {24'd0, onehot},  {24'd0, oh});
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; req = 8'hFF; mask = 8'hFF; ack = 1'b0;
        @(negedge clock);

        // Reset dominates active requests.
        step(); chk_all("reset1", 8'h00, 3'd0, 1'b0, 8'h00);
        step(); chk_all("reset2", 8'h00, 3'd0, 1'b0, 8'h00);
        reset = 1'b0;
        step(); chk_all("capture_ff", 8'hFF, 3'd0, 1'b1, 8'h01);
        req = 8'h00;

        // Full drain: codes 0..7 on successive cycles, then idle.
        ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_code", {29'd0, code}, i);
            chk("drain_valid", {31'd0, valid}, 32'd1);
            step();
        end
        chk_all("drain_done", 8'h00, 3'd0, 1'b0, 8'h00);
        ack = 1'b0;

        // Single pulse then ack.
        req = 8'h20;
        step(); req = 8'h00;
        chk_all("single", 8'h20, 3'd5, 1'b1, 8'h20);
        ack = 1'b1;
        step(); ack = 1'b0;
        chk_all("single_ack", 8'h00, 3'd0, 1'b0, 8'h00);

        // Preemption: ack clears the presented bit 7, new bit 1 takes over.
        req = 8'h80;
        step(); req = 8'h00;
        chk_all("pend80", 8'h80, 3'd7, 1'b1, 8'h80);
        req = 8'h02; ack = 1'b1;
        step();
        chk_all("preempt", 8'h02, 3'd1, 1'b1, 8'h02);
        // Collision: request on the acked bit wins.
        step();
        chk_all("collide", 8'h02, 3'd1, 1'b1, 8'h02);
        req = 8'h00;
        step(); ack = 1'b0;
        chk_all("collide_drain", 8'h00, 3'd0, 1'b0, 8'h00);

        // Gating by en and mask.
        en = 1'b0; req = 8'h0F;
        step();
        chk_all("en_off", 8'h00, 3'd0, 1'b0, 8'h00);
        en = 1'b1; mask = 8'hF0; req = 8'hFF;
        step(); req = 8'h00; mask = 8'hFF;
        chk_all("mask", 8'hF0, 3'd4, 1'b1, 8'h10);

        // Reset mid-service drops everything, even with ack and req active.
        reset = 1'b1; ack = 1'b1; req = 8'h01;
        step(); reset = 1'b0; req = 8'h00;
        chk_all("mid_reset", 8'h00, 3'd0, 1'b0, 8'h00);

        // Spurious ack while idle.
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("spurious_ack", 8'h00, 3'd0, 1'b0, 8'h00);
        end
        ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
